// File: rtl/ntt_agu_pkg.sv
// rtl/ntt_agu_pkg.sv - shared state type and sizing helpers for the NTT address scheduler
package ntt_agu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      GAP   = 2'd2,
      DRAIN = 2'd3
   } agu_state_e;

   localparam int DEF_DEGREE_WIDTH  = 16;
   localparam int DEF_DELTA         = 4;
   localparam int DEF_D_WIDTH       = 32;
   localparam int DEF_STAGE_GAP     = 8;
   localparam int DEF_TRANSLATE_LAT = 4;

   // S: number of radix-2^DELTA stages
   function automatic int num_stages(input int dw, input int d);
      return dw / d;
   endfunction

   // G: butterfly groups per stage (N / R)
   function automatic int num_groups(input int dw, input int d);
      return 1 << (dw - d);
   endfunction

   // stage counter width, never narrower than one bit
   function automatic int stage_w(input int dw, input int d);
      int s;
      s = dw / d;
      return (s > 1) ? $clog2(s) : 1;
   endfunction

   // group counter width, never narrower than one bit
   function automatic int group_w(input int dw, input int d);
      return (dw > d) ? (dw - d) : 1;
   endfunction

   // shared gap/drain counter must reach max(STAGE_GAP, TRANSLATE_LAT)
   function automatic int cnt_w(input int gap, input int lat);
      int m;
      m = (gap > lat) ? gap : lat;
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/ntt_order_compose.sv
// rtl/ntt_order_compose.sv - combinational (stage, group, element) to point order
//   s     in  stage index
//   g     in  group index
//   j     in  element index within the group
//   order out point index, zero-extended to D_WIDTH
module ntt_order_compose
   import ntt_agu_pkg::*;
#(
   parameter int DEGREE_WIDTH = DEF_DEGREE_WIDTH,
   parameter int DELTA        = DEF_DELTA,
   parameter int D_WIDTH      = DEF_D_WIDTH
) (
   input  logic [stage_w(DEGREE_WIDTH, DELTA)-1:0] s,
   input  logic [group_w(DEGREE_WIDTH, DELTA)-1:0] g,
   input  logic [DELTA-1:0]                        j,
   output logic [D_WIDTH-1:0]                      order
);

   logic [DEGREE_WIDTH-1:0] g_ext;
   logic [DEGREE_WIDTH-1:0] low_mask;
   logic [DEGREE_WIDTH-1:0] low;
   logic [DEGREE_WIDTH-1:0] high;
   logic [DEGREE_WIDTH-1:0] res;
   int                      lo_bits;

   // The element index j is inserted as a DELTA-bit field at bit s*DELTA;
   // group bits below that field stay put, the rest move up by DELTA.
   always_comb begin
      lo_bits  = int'(s) * DELTA;
      g_ext    = DEGREE_WIDTH'(g);
      low_mask = (DEGREE_WIDTH'(1) << lo_bits) - DEGREE_WIDTH'(1);
      low      = g_ext & low_mask;
      high     = g_ext >> lo_bits;
      res      = (high << (lo_bits + DELTA)) | (DEGREE_WIDTH'(j) << lo_bits) | low;
      order    = D_WIDTH'(res);
   end

endmodule

// File: rtl/ntt_agu_scheduler.sv
// rtl/ntt_agu_scheduler.sv - NTT order stream scheduler: stages, gaps, stalls, drain
//   clk, rst     clock, asynchronous active-high reset
//   start, inv   transform request and stage direction (sampled with accepted start)
//   stall        holds order generation while running
//   order        point index to the translator
//   order_valid  translator read enable
//   agu_done     final order of the final stage
//   stage_last   last order of each stage
//   cur_stage    stage of the current order
//   busy, done   transform in progress, one-cycle completion pulse
module ntt_agu_scheduler
   import ntt_agu_pkg::*;
#(
   parameter int DEGREE_WIDTH  = DEF_DEGREE_WIDTH,
   parameter int DELTA         = DEF_DELTA,
   parameter int D_WIDTH       = DEF_D_WIDTH,
   parameter int STAGE_GAP     = DEF_STAGE_GAP,
   parameter int TRANSLATE_LAT = DEF_TRANSLATE_LAT
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic                                    inv,
   input  logic                                    stall,
   output logic [D_WIDTH-1:0]                      order,
   output logic                                    order_valid,
   output logic                                    agu_done,
   output logic                                    stage_last,
   output logic [stage_w(DEGREE_WIDTH, DELTA)-1:0] cur_stage,
   output logic                                    busy,
   output logic                                    done
);

   localparam int S  = num_stages(DEGREE_WIDTH, DELTA);
   localparam int G  = num_groups(DEGREE_WIDTH, DELTA);
   localparam int SW = stage_w(DEGREE_WIDTH, DELTA);
   localparam int GW = group_w(DEGREE_WIDTH, DELTA);
   localparam int CW = cnt_w(STAGE_GAP, TRANSLATE_LAT);

   localparam logic [SW-1:0]    S_LAST  = SW'(S - 1);
   localparam logic [GW-1:0]    G_LAST  = GW'(G - 1);
   localparam logic [DELTA-1:0] J_LAST  = '1;
   // GAP is entered in the stage_last cycle, so it spans STAGE_GAP+1 cycles
   // with the next stage's first order issued on the last of them.
   localparam logic [CW-1:0]    GAP_END = CW'(STAGE_GAP);
   localparam logic [CW-1:0]    LAT_END = CW'((TRANSLATE_LAT > 0) ? TRANSLATE_LAT - 1 : 0);

   agu_state_e        state_q, state_d;
   logic [SW-1:0]     s_q, s_d;
   logic [GW-1:0]     g_q, g_d;
   logic [DELTA-1:0]  j_q, j_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              inv_q, inv_d;

   logic [D_WIDTH-1:0] order_d;
   logic               valid_d, agu_done_d, stage_last_d, busy_d, done_d;
   logic [SW-1:0]      cur_stage_d;

   // Counters always point at the next order to issue. In IDLE the first
   // order of a run is issued straight from the start position.
   logic [SW-1:0]      s_first, s_final, s_adv;
   logic [SW-1:0]      src_s;
   logic [GW-1:0]      src_g;
   logic [DELTA-1:0]   src_j;
   logic [D_WIDTH-1:0] src_order;
   logic               emit, at_stage_end, at_final;

   assign s_first = inv ? S_LAST : '0;
   // inv_q is stale during the IDLE issue, but that order (j=0) can never
   // be the last of a stage, so s_final is never consulted then.
   assign s_final = inv_q ? '0 : S_LAST;
   assign src_s   = (state_q == IDLE) ? s_first : s_q;
   assign src_g   = (state_q == IDLE) ? '0 : g_q;
   assign src_j   = (state_q == IDLE) ? '0 : j_q;
   assign s_adv   = inv_q ? (src_s - 1'b1) : (src_s + 1'b1);

   assign at_stage_end = (src_j == J_LAST) && (src_g == G_LAST);
   assign at_final     = at_stage_end && (src_s == s_final);

   ntt_order_compose #(
      .DEGREE_WIDTH(DEGREE_WIDTH),
      .DELTA       (DELTA),
      .D_WIDTH     (D_WIDTH)
   ) u_compose (
      .s    (src_s),
      .g    (src_g),
      .j    (src_j),
      .order(src_order)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         s_q         <= '0;
         g_q         <= '0;
         j_q         <= '0;
         cnt_q       <= '0;
         inv_q       <= 1'b0;
         order       <= '0;
         order_valid <= 1'b0;
         agu_done    <= 1'b0;
         stage_last  <= 1'b0;
         cur_stage   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         g_q         <= g_d;
         j_q         <= j_d;
         cnt_q       <= cnt_d;
         inv_q       <= inv_d;
         order       <= order_d;
         order_valid <= valid_d;
         agu_done    <= agu_done_d;
         stage_last  <= stage_last_d;
         cur_stage   <= cur_stage_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      g_d          = g_q;
      j_d          = j_q;
      cnt_d        = cnt_q;
      inv_d        = inv_q;
      busy_d       = busy;
      order_d      = '0;
      valid_d      = 1'b0;
      agu_done_d   = 1'b0;
      stage_last_d = 1'b0;
      cur_stage_d  = '0;
      done_d       = 1'b0;
      emit         = 1'b0;

      unique case (state_q)
         IDLE: begin
            // busy still high here means this is the done cycle: drop busy,
            // and ignore start until busy is observed low.
            if (busy) begin
               busy_d = 1'b0;
            end else if (start) begin
               emit   = 1'b1;
               inv_d  = inv;
               busy_d = 1'b1;
            end
         end
         RUN: begin
            emit = !stall;
         end
         GAP: begin
            if (cnt_q == GAP_END) begin
               emit = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == LAT_END) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (emit) begin
         order_d      = src_order;
         valid_d      = 1'b1;
         cur_stage_d  = src_s;
         stage_last_d = at_stage_end;
         agu_done_d   = at_final;
         if (!at_stage_end) begin
            state_d = RUN;
            s_d     = src_s;
            j_d     = src_j + 1'b1;
            g_d     = (src_j == J_LAST) ? (src_g + 1'b1) : src_g;
         end else if (!at_final) begin
            s_d     = s_adv;
            g_d     = '0;
            j_d     = '0;
            cnt_d   = '0;
            state_d = (STAGE_GAP == 0) ? RUN : GAP;
         end else begin
            s_d   = '0;
            g_d   = '0;
            j_d   = '0;
            cnt_d = '0;
            if (TRANSLATE_LAT == 0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
      end
   end

endmodule

// File: tb/tb_ntt_agu_scheduler.sv
// tb/tb_ntt_agu_scheduler.sv - self-checking bench for ntt_agu_scheduler
module tb_ntt_agu_scheduler;

   localparam int DW      = 8;
   localparam int DLT     = 4;
   localparam int TL      = 4;
   localparam int S       = DW / DLT;
   localparam int R       = 1 << DLT;
   localparam int G       = 1 << (DW - DLT);
   localparam int MAXC    = 3000;
   localparam int END_CYC = 2925;
   localparam int NF      = 7;

   localparam int F_ORDER = 0;
   localparam int F_VALID = 1;
   localparam int F_LAST  = 2;
   localparam int F_AGU   = 3;
   localparam int F_STAGE = 4;
   localparam int F_BUSY  = 5;
   localparam int F_DONE  = 6;

   logic        clk = 1'b0;
   logic        rst, start, start0, inv, stall;
   logic [31:0] order, order0;
   logic        order_valid, agu_done, stage_last, busy, done;
   logic        order_valid0, agu_done0, stage_last0, busy0, done0;
   logic [0:0]  cur_stage, cur_stage0;

   int cyc = 0;
   int n_err = 0;
   int n_checks = 0;
   int exp_f[2][NF][MAXC];

   typedef struct {
      int c;
      int d;
      int f;
      int v;
   } pin_t;

   localparam int NPIN = 37;
   pin_t pins[NPIN] = '{
      '{27, 0, F_ORDER, 16},    '{42, 0, F_ORDER, 31},    '{285, 0, F_ORDER, 1},
      '{300, 0, F_ORDER, 241},  '{266, 0, F_LAST, 1},     '{524, 0, F_LAST, 1},
      '{524, 0, F_AGU, 1},      '{528, 0, F_DONE, 1},     '{528, 0, F_BUSY, 1},
      '{529, 0, F_BUSY, 0},     '{267, 0, F_VALID, 0},    '{268, 0, F_VALID, 0},
      '{269, 0, F_VALID, 1},    '{266, 1, F_LAST, 1},     '{267, 1, F_VALID, 1},
      '{268, 1, F_ORDER, 16},   '{522, 1, F_AGU, 1},      '{526, 1, F_DONE, 1},
      '{530, 0, F_STAGE, 1},    '{531, 0, F_ORDER, 16},   '{788, 0, F_STAGE, 0},
      '{789, 0, F_ORDER, 1},    '{1047, 0, F_DONE, 1},    '{1068, 0, F_ORDER, 7},
      '{1069, 0, F_VALID, 0},   '{1073, 0, F_VALID, 0},   '{1074, 0, F_ORDER, 8},
      '{1583, 0, F_DONE, 1},    '{1860, 0, F_ORDER, 16},  '{2118, 0, F_DONE, 1},
      '{2119, 0, F_BUSY, 0},    '{2387, 0, F_BUSY, 0},    '{2393, 0, F_VALID, 1},
      '{2393, 0, F_STAGE, 0},   '{2409, 0, F_ORDER, 16},  '{2910, 0, F_DONE, 1},
      '{2911, 0, F_BUSY, 0}
   };

   string fname[NF] = '{"order", "order_valid", "stage_last", "agu_done", "cur_stage", "busy", "done"};

   ntt_agu_scheduler #(
      .DEGREE_WIDTH (DW),
      .DELTA        (DLT),
      .D_WIDTH      (32),
      .STAGE_GAP    (2),
      .TRANSLATE_LAT(TL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .inv        (inv),
      .stall      (stall),
      .order      (order),
      .order_valid(order_valid),
      .agu_done   (agu_done),
      .stage_last (stage_last),
      .cur_stage  (cur_stage),
      .busy       (busy),
      .done       (done)
   );

   ntt_agu_scheduler #(
      .DEGREE_WIDTH (DW),
      .DELTA        (DLT),
      .D_WIDTH      (32),
      .STAGE_GAP    (0),
      .TRANSLATE_LAT(TL)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start0),
      .inv        (inv),
      .stall      (stall),
      .order      (order0),
      .order_valid(order_valid0),
      .agu_done   (agu_done0),
      .stage_last (stage_last0),
      .cur_stage  (cur_stage0),
      .busy       (busy0),
      .done       (done0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // point index: the element index becomes base-R digit s of the order,
   // the group's digits below s stay, those at or above s move up one digit
   function automatic int ref_order(input int s, input int g, input int j);
      int span;
      span = 1;
      for (int k = 0; k < s; k++) span = span * R;
      return (g / span) * span * R + j * span + (g % span);
   endfunction

   // expected timeline of one accepted start in cycle t0; stall is active
   // in cycles st_lo .. st_lo+st_n-1 and only delays orders inside a stage
   task automatic model_run(input int d, input int t0, input bit inv_v,
                            input int st_lo, input int st_n, input int gap);
      int t;
      int s;
      t = t0 + 1;
      for (int si = 0; si < S; si++) begin
         s = inv_v ? (S - 1 - si) : si;
         for (int g = 0; g < G; g++) begin
            for (int j = 0; j < R; j++) begin
               if (!(g == 0 && j == 0)) begin
                  while ((t - 1) >= st_lo && (t - 1) < st_lo + st_n) t++;
               end
               exp_f[d][F_VALID][t] = 1;
               exp_f[d][F_ORDER][t] = ref_order(s, g, j);
               exp_f[d][F_STAGE][t] = s;
               exp_f[d][F_LAST][t]  = (g == G - 1 && j == R - 1) ? 1 : 0;
               exp_f[d][F_AGU][t]   = (g == G - 1 && j == R - 1 && si == S - 1) ? 1 : 0;
               t++;
            end
         end
         if (si != S - 1) t = t + gap;
      end
      exp_f[d][F_DONE][t - 1 + TL] = 1;
      for (int c = t0 + 1; c <= t - 1 + TL; c++) exp_f[d][F_BUSY][c] = 1;
   endtask

   task automatic model_clear(input int d, input int from);
      for (int c = from; c < MAXC; c++)
         for (int f = 0; f < NF; f++) exp_f[d][f][c] = 0;
   endtask

   task automatic check_lit(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int get_act(input int d, input int f);
      case (f)
         F_ORDER: return (d == 0) ? int'(order)       : int'(order0);
         F_VALID: return (d == 0) ? int'(order_valid) : int'(order_valid0);
         F_LAST:  return (d == 0) ? int'(stage_last)  : int'(stage_last0);
         F_AGU:   return (d == 0) ? int'(agu_done)    : int'(agu_done0);
         F_STAGE: return (d == 0) ? int'(cur_stage)   : int'(cur_stage0);
         F_BUSY:  return (d == 0) ? int'(busy)        : int'(busy0);
         default: return (d == 0) ? int'(done)        : int'(done0);
      endcase
   endfunction

   always @(negedge clk) begin
      bit bad;
      if (cyc >= 1 && cyc <= END_CYC) begin
         for (int d = 0; d < 2; d++) begin
            bad = 1'b0;
            for (int f = 0; f < NF; f++)
               if (get_act(d, f) != exp_f[d][f][cyc]) bad = 1'b1;
            n_checks++;
            if (bad) begin
               n_err++;
               $display("FAIL cycle%0d_dut%0d: got ord=%0d v=%0d last=%0d agu=%0d stg=%0d busy=%0d done=%0d, expected ord=%0d v=%0d last=%0d agu=%0d stg=%0d busy=%0d done=%0d",
                        cyc, d, get_act(d, 0), get_act(d, 1), get_act(d, 2), get_act(d, 3),
                        get_act(d, 4), get_act(d, 5), get_act(d, 6),
                        exp_f[d][0][cyc], exp_f[d][1][cyc], exp_f[d][2][cyc], exp_f[d][3][cyc],
                        exp_f[d][4][cyc], exp_f[d][5][cyc], exp_f[d][6][cyc]);
            end
         end
         for (int p = 0; p < NPIN; p++) begin
            if (pins[p].c == cyc) begin
               n_checks++;
               if (get_act(pins[p].d, pins[p].f) != pins[p].v) begin
                  n_err++;
                  $display("FAIL pin_c%0d_dut%0d_%s: got %0d, expected %0d", pins[p].c, pins[p].d,
                           fname[pins[p].f], get_act(pins[p].d, pins[p].f), pins[p].v);
               end
            end
         end
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      start0 = 1'b0;
      inv    = 1'b0;
      stall  = 1'b0;

      model_run(0, 10, 1'b0, -10, 0, 2);
      model_run(1, 10, 1'b0, -10, 0, 0);
      model_run(0, 529, 1'b1, -10, 0, 2);
      model_run(0, 1060, 1'b0, 1068, 5, 2);
      model_run(0, 1600, 1'b0, -10, 0, 2);
      model_run(0, 2130, 1'b0, -10, 0, 2);
      model_clear(0, 2387);
      model_run(0, 2392, 1'b0, -10, 0, 2);

      check_lit("model_order_s0_g1_j0", ref_order(0, 1, 0), 16);
      check_lit("model_order_s1_g1_j15", ref_order(1, 1, 15), 241);
      check_lit("model_order_s1_g0_j1", ref_order(1, 0, 1), 16);
      check_lit("model_last_266", exp_f[0][F_LAST][266], 1);
      check_lit("model_done_fwd", exp_f[0][F_DONE][528], 1);
      check_lit("model_done_stall", exp_f[0][F_DONE][1583], 1);
      check_lit("model_done_gap0", exp_f[1][F_DONE][526], 1);

      goto(3);
      rst = 1'b0;

      goto(10);
      start = 1'b1; start0 = 1'b1; inv = 1'b0;
      goto(11);
      start = 1'b0; start0 = 1'b0;

      goto(528);
      start = 1'b1; inv = 1'b1;
      goto(530);
      start = 1'b0; inv = 1'b0;

      goto(1060);
      start = 1'b1;
      goto(1061);
      start = 1'b0;
      goto(1068);
      stall = 1'b1;
      goto(1073);
      stall = 1'b0;

      goto(1600);
      start = 1'b1;
      goto(1601);
      start = 1'b0;
      goto(1700);
      start = 1'b1; inv = 1'b1;
      goto(1701);
      start = 1'b0;
      goto(1857);
      start = 1'b1;
      goto(1858);
      start = 1'b0;
      goto(2118);
      start = 1'b1;
      goto(2119);
      start = 1'b0; inv = 1'b0;

      goto(2130);
      start = 1'b1;
      goto(2131);
      start = 1'b0;
      goto(2387);
      rst = 1'b1;
      goto(2388);
      rst = 1'b0;
      goto(2392);
      start = 1'b1;
      goto(2393);
      start = 1'b0;

      goto(END_CYC + 2);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
